// File: rtl/mult_pkg.sv
// Widths and limits for the nibble-serial 16x16 multiplier.
// The datapath and its controller both import this package.
package mult_pkg;
    localparam int NIB_W   = 4;
    localparam int OP_W    = 16;
    localparam int PROD_W  = 32;
    localparam int PP_W    = 2 * NIB_W;
    localparam int COUNT_W = 4;
    localparam logic [2:0] MAX_SHIFT = 3'd6;
endpackage

// File: rtl/mult4x4.sv
// Unsigned 4x4 multiplier producing an 8-bit partial product.
// Purely combinational; the result is valid in the same cycle, with no handshake.
module mult4x4
    import mult_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [PP_W-1:0]  p
);

    assign p = PP_W'(a) * PP_W'(b);

endmodule

// File: rtl/mult_datapath.sv
// Datapath for the nibble-serial multiplier: latches operands and accumulates shifted 4x4 products.
// Product is ready 16 steps after clear, plus one edge after done rises; no backpressure (controller paced).
module mult_datapath
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_a_n,
    input  logic [OP_W-1:0]      dataa,
    input  logic [OP_W-1:0]      datab,
    input  logic [3:0]           input_sel,
    input  logic [2:0]           shift_sel,
    input  logic                 clk_ena,
    input  logic                 sclr_n,
    input  logic                 done,
    output logic [COUNT_W-1:0]   count,
    output logic [PROD_W-1:0]    product,
    output logic                 product_valid,
    output logic [PROD_W-1:0]    acc_out
);

    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [PROD_W-1:0]  r_acc;
    logic [COUNT_W-1:0] r_count;
    logic [PROD_W-1:0]  r_product;
    logic               r_product_valid;
    logic               r_done_d;

    logic [NIB_W-1:0]   w_a_nib;
    logic [NIB_W-1:0]   w_b_nib;
    logic [PP_W-1:0]    w_pp;
    logic [PROD_W-1:0]  w_pp_ext;
    logic [PROD_W-1:0]  w_addend;
    logic               w_done_rise;

    // Nibbles come from the latched operands so the live inputs may change mid-run.
    assign w_a_nib = r_a[{input_sel[3:2], 2'b00} +: NIB_W];
    assign w_b_nib = r_b[{input_sel[1:0], 2'b00} +: NIB_W];

    mult4x4 u_mult4x4 (
        .a (w_a_nib),
        .b (w_b_nib),
        .p (w_pp)
    );

    assign w_pp_ext = {{(PROD_W-PP_W){1'b0}}, w_pp};
    // An out-of-range shift contributes nothing rather than a truncated product.
    assign w_addend = (shift_sel > MAX_SHIFT) ? '0 : (w_pp_ext << {shift_sel, 2'b00});

    assign w_done_rise = done & ~r_done_d;

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (clk_ena) begin
            if (!sclr_n) begin
                r_a     <= dataa;
                r_b     <= datab;
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= r_acc + w_addend;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Captures the accumulator as it stood before this edge, so a coincident clear cannot corrupt it.
    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            r_done_d        <= 1'b0;
            r_product       <= '0;
            r_product_valid <= 1'b0;
        end else begin
            r_done_d        <= done;
            r_product_valid <= w_done_rise;
            if (w_done_rise) begin
                r_product <= r_acc;
            end
        end
    end

    assign count         = r_count;
    assign product       = r_product;
    assign product_valid = r_product_valid;
    assign acc_out       = r_acc;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: known products, hold/clear/done/reset corner cases.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        reset_a_n;
    logic [15:0] dataa;
    logic [15:0] datab;
    logic [3:0]  input_sel;
    logic [2:0]  shift_sel;
    logic        clk_ena;
    logic        sclr_n;
    logic        done;
    logic [3:0]  count;
    logic [31:0] product;
    logic        product_valid;
    logic [31:0] acc_out;

    int n_vec = 0;
    int n_err = 0;

    mult_datapath dut (
        .clk           (clk),
        .reset_a_n     (reset_a_n),
        .dataa         (dataa),
        .datab         (datab),
        .input_sel     (input_sel),
        .shift_sel     (shift_sel),
        .clk_ena       (clk_ena),
        .sclr_n        (sclr_n),
        .done          (done),
        .count         (count),
        .product       (product),
        .product_valid (product_valid),
        .acc_out       (acc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_clear(input logic [15:0] a, input logic [15:0] b);
        dataa   = a;
        datab   = b;
        clk_ena = 1'b1;
        sclr_n  = 1'b0;
        tick();
        clk_ena = 1'b0;
        sclr_n  = 1'b1;
    endtask

    task automatic do_steps(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [3:0] sel;
            sel       = 4'(i);
            input_sel = sel;
            shift_sel = 3'(sel[3:2]) + 3'(sel[1:0]);
            clk_ena   = 1'b1;
            sclr_n    = 1'b1;
            tick();
        end
        clk_ena = 1'b0;
    endtask

    task automatic done_pulse(input string tag, input logic [31:0] exp_prod);
        done = 1'b1;
        tick();
        chk({tag, "_product"}, product, exp_prod);
        chk({tag, "_valid_hi"}, 32'(product_valid), 32'd1);
        done = 1'b0;
        tick();
        chk({tag, "_valid_lo"}, 32'(product_valid), 32'd0);
    endtask

    initial begin
        reset_a_n = 1'b1;
        dataa = '0; datab = '0; input_sel = '0; shift_sel = '0;
        clk_ena = 1'b0; sclr_n = 1'b1; done = 1'b0;
        #3 reset_a_n = 1'b0;
        tick();
        chk("rst_product", product, 32'h0);
        chk("rst_valid", 32'(product_valid), 32'd0);
        chk("rst_acc", acc_out, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        reset_a_n = 1'b1;
        tick();

        // 0x1234 x 0x5678, live dataa changed after clear; done held 4 cycles
        do_clear(16'h1234, 16'h5678);
        dataa = 16'hFFFF;
        do_steps(0, 15);
        chk("t1_acc", acc_out, 32'h06260060);
        chk("t1_count_wrap", 32'(count), 32'd0);
        done = 1'b1;
        tick();
        chk("t1_product", product, 32'h06260060);
        chk("t1_valid_hi", 32'(product_valid), 32'd1);
        tick();
        chk("t1_valid_lo1", 32'(product_valid), 32'd0);
        tick();
        chk("t1_valid_lo2", 32'(product_valid), 32'd0);
        tick();
        done = 1'b0;
        tick();
        chk("t1_valid_lo3", 32'(product_valid), 32'd0);

        // 0xFFFF x 0xFFFF; earlier product must hold through clear and steps
        do_clear(16'hFFFF, 16'hFFFF);
        chk("t2_hold_after_clr", product, 32'h06260060);
        chk("t2_acc_clr", acc_out, 32'h0);
        do_steps(0, 15);
        chk("t2_acc", acc_out, 32'hFFFE0001);
        chk("t2_hold_before_done", product, 32'h06260060);
        done_pulse("t2", 32'hFFFE0001);

        // 0x0000 x 0xBEEF
        do_clear(16'h0000, 16'hBEEF);
        do_steps(0, 15);
        chk("t3_hold", product, 32'hFFFE0001);
        done_pulse("t3", 32'h00000000);

        // Hold with X selects, then a shift_sel=7 step
        do_clear(16'h1234, 16'h5678);
        do_steps(0, 7);
        chk("t4_acc_half", acc_out, 32'h00119060);
        chk("t4_count_half", 32'(count), 32'd8);
        input_sel = 'x;
        shift_sel = 'x;
        clk_ena   = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t4_acc_hold", acc_out, 32'h00119060);
        chk("t4_count_hold", 32'(count), 32'd8);
        input_sel = 4'hF;
        shift_sel = 3'd7;
        clk_ena   = 1'b1;
        tick();
        clk_ena = 1'b0;
        chk("t4_sh7_acc", acc_out, 32'h00119060);
        chk("t4_sh7_count", 32'(count), 32'd9);
        do_steps(8, 15);
        chk("t4_acc_full", acc_out, 32'h06260060);
        chk("t4_count", 32'(count), 32'd1);

        // done rise coincident with clear: product takes pre-clear acc
        done    = 1'b1;
        dataa   = 16'h0003;
        datab   = 16'h0005;
        clk_ena = 1'b1;
        sclr_n  = 1'b0;
        tick();
        clk_ena = 1'b0;
        sclr_n  = 1'b1;
        done    = 1'b0;
        chk("t5_product", product, 32'h06260060);
        chk("t5_valid", 32'(product_valid), 32'd1);
        chk("t5_acc_clr", acc_out, 32'h0);
        chk("t5_count_clr", 32'(count), 32'd0);

        // Reset mid-sequence, then a fresh 3 x 5 run
        do_steps(0, 7);
        chk("t6_acc_mid", acc_out, 32'h0000000F);
        #2 reset_a_n = 1'b0;
        #1;
        chk("t6_rst_product", product, 32'h0);
        chk("t6_rst_acc", acc_out, 32'h0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_valid", 32'(product_valid), 32'd0);
        tick();
        reset_a_n = 1'b1;
        tick();
        do_clear(16'h0003, 16'h0005);
        do_steps(0, 15);
        chk("t6_count", 32'(count), 32'd0);
        done_pulse("t6", 32'h0000000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
